// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - time-multiplexed leaky integrate-and-fire neuron array
// Round-robin membrane update per accepted sample through a two-stage pipeline.
module lif_neuron_array #(
    parameter int N_NEURONS = 8,
    parameter int V_W       = 16,
    parameter int I_W       = 8,
    parameter int I_SHIFT   = 6,
    parameter int REF_W     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_addr,
    input  logic [V_W-1:0]               cfg_data,
    input  logic                         cfg_go,
    input  logic                         cfg_stop,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [I_W-1:0]               in_i,
    output logic                         out_valid,
    output logic [$clog2(N_NEURONS)-1:0] out_idx,
    output logic [V_W-1:0]               out_v,
    output logic                         out_spike,
    output logic                         busy
);
    localparam int IDX_W = $clog2(N_NEURONS);
    localparam int P_W   = 2 * (V_W + 1);
    localparam int S_W   = P_W + I_W + I_SHIFT;

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
    logic [V_W-1:0]    e_rest_q, e_rest_d;
    logic [V_W-1:0]    e_tau_q, e_tau_d;
    logic [V_W-1:0]    v_th_q, v_th_d;
    logic [REF_W-1:0]  t_ref_q, t_ref_d;

    logic              s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
    logic [I_W-1:0]    s1_in_q, s1_in_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [IDX_W-1:0]      s2_idx_q, s2_idx_d;
    logic [I_W-1:0]        s2_in_q, s2_in_d;
    logic signed [P_W-1:0] s2_p_q, s2_p_d;
    logic [REF_W-1:0]      s2_ref_q, s2_ref_d;

    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [V_W-1:0]    out_v_q, out_v_d;
    logic              out_spike_q, out_spike_d;

    logic [V_W-1:0]    v_mem [N_NEURONS];
    logic [REF_W-1:0]  ref_mem [N_NEURONS];
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [V_W-1:0]    wr_v;
    logic [REF_W-1:0]  wr_ref;

    logic                  accept;
    logic [V_W-1:0]        rd_v;
    logic signed [V_W:0]   diff;
    logic signed [P_W-1:0] diff_x, tau_x, prod;
    logic signed [S_W-1:0] sum;
    logic [V_W-1:0]        sat_v;
    logic                  fire;
    logic [V_W-1:0]        new_v;
    logic [REF_W-1:0]      new_ref;
    logic                  new_spike;

    assign in_ready  = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_v     = out_v_q;
    assign out_spike = out_spike_q;
    assign accept    = in_valid && in_ready;

    // Stage 2 reads the membrane one cycle after acceptance, so with N >= 2 the
    // previous write-back of the same neuron has always landed already.
    always_comb begin
        rd_v     = v_mem[s1_idx_q];
        diff     = $signed({rd_v[V_W-1], rd_v}) - $signed({e_rest_q[V_W-1], e_rest_q});
        diff_x   = P_W'(diff);
        tau_x    = $signed(P_W'(e_tau_q));
        prod     = diff_x * tau_x;
        s2_p_d   = prod >>> 8;
        s2_ref_d = ref_mem[s1_idx_q];
    end

    always_comb begin
        sum = S_W'($signed(e_rest_q)) + S_W'({s2_in_q, {I_SHIFT{1'b0}}}) + S_W'(s2_p_q);
        if (sum[S_W-1:V_W-1] == {(S_W-V_W+1){sum[S_W-1]}}) begin
            sat_v = sum[V_W-1:0];
        end else begin
            sat_v = sum[S_W-1] ? {1'b1, {(V_W-1){1'b0}}} : {1'b0, {(V_W-1){1'b1}}};
        end
        fire      = ($signed(sat_v) >= $signed(v_th_q));
        new_v     = sat_v;
        new_ref   = '0;
        new_spike = 1'b0;
        if (s2_ref_q != '0) begin
            new_v   = e_rest_q;
            new_ref = s2_ref_q - REF_W'(1);
        end else if (fire) begin
            new_v     = e_rest_q;
            new_ref   = t_ref_q;
            new_spike = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_cnt_d  = init_cnt_q;
        e_rest_d    = e_rest_q;
        e_tau_d     = e_tau_q;
        v_th_d      = v_th_q;
        t_ref_d     = t_ref_q;
        s1_valid_d  = accept;
        s1_idx_d    = s1_idx_q;
        s1_in_d     = s1_in_q;
        s2_valid_d  = s1_valid_q;
        s2_idx_d    = s1_idx_q;
        s2_in_d     = s1_in_q;
        out_valid_d = s2_valid_q;
        out_idx_d   = out_idx_q;
        out_v_d     = out_v_q;
        out_spike_d = out_spike_q;
        wr_en       = 1'b0;
        wr_idx      = s2_idx_q;
        wr_v        = new_v;
        wr_ref      = new_ref;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    case (cfg_addr)
                        2'd0:    e_rest_d = cfg_data;
                        2'd1:    e_tau_d  = cfg_data;
                        2'd2:    v_th_d   = cfg_data;
                        default: t_ref_d  = cfg_data[REF_W-1:0];
                    endcase
                end
                if (cfg_go) begin
                    state_d    = ST_INIT;
                    ptr_d      = '0;
                    init_cnt_d = '0;
                end
            end
            ST_INIT: begin
                wr_en      = 1'b1;
                wr_idx     = init_cnt_q;
                wr_v       = e_rest_q;
                wr_ref     = '0;
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == IDX_W'(N_NEURONS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    s1_idx_d = ptr_q;
                    s1_in_d  = in_i;
                    ptr_d    = (ptr_q == IDX_W'(N_NEURONS - 1)) ? '0 : ptr_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (s2_valid_q) begin
            wr_en       = 1'b1;
            out_idx_d   = s2_idx_q;
            out_v_d     = new_v;
            out_spike_d = new_spike;
        end

        // Stop drops everything in flight, including the write-back on this edge.
        if (cfg_stop) begin
            state_d     = ST_IDLE;
            s1_valid_d  = 1'b0;
            s2_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            wr_en       = 1'b0;
            out_idx_d   = out_idx_q;
            out_v_d     = out_v_q;
            out_spike_d = out_spike_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            init_cnt_q  <= '0;
            e_rest_q    <= '0;
            e_tau_q     <= '0;
            v_th_q      <= '0;
            t_ref_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_in_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_idx_q    <= '0;
            s2_in_q     <= '0;
            s2_p_q      <= '0;
            s2_ref_q    <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_v_q     <= '0;
            out_spike_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_cnt_q  <= init_cnt_d;
            e_rest_q    <= e_rest_d;
            e_tau_q     <= e_tau_d;
            v_th_q      <= v_th_d;
            t_ref_q     <= t_ref_d;
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_in_q     <= s1_in_d;
            s2_valid_q  <= s2_valid_d;
            s2_idx_q    <= s2_idx_d;
            s2_in_q     <= s2_in_d;
            s2_p_q      <= s2_p_d;
            s2_ref_q    <= s2_ref_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_v_q     <= out_v_d;
            out_spike_q <= out_spike_d;
        end
    end

    // Neuron state is not reset; INIT establishes it.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            v_mem[wr_idx]   <= wr_v;
            ref_mem[wr_idx] <= wr_ref;
        end
    end
endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - directed self-checking bench for lif_neuron_array
module tb_lif_neuron_array;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        cfg_go = 1'b0;
    logic        cfg_stop = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_i = '0;
    logic        out_valid;
    logic [2:0]  out_idx;
    logic [15:0] out_v;
    logic        out_spike;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int acc_q[$];
    int o_idx[$];
    int o_v[$];
    int o_spk[$];
    int o_lat[$];
    int exp_v[$];
    int exp_s[$];

    lif_neuron_array dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_go(cfg_go), .cfg_stop(cfg_stop), .in_valid(in_valid), .in_ready(in_ready),
        .in_i(in_i), .out_valid(out_valid), .out_idx(out_idx), .out_v(out_v),
        .out_spike(out_spike), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            o_idx.push_back(int'(out_idx));
            o_v.push_back(int'(out_v));
            o_spk.push_back(int'(out_spike));
            if (acc_q.size() > 0) o_lat.push_back(edge_n - 1 - acc_q.pop_front());
            else o_lat.push_back(-1);
        end
        if (in_valid && in_ready && !rst) acc_q.push_back(edge_n);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        acc_q.delete(); o_idx.delete(); o_v.delete(); o_spk.delete(); o_lat.delete();
        exp_v.delete(); exp_s.delete();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go_and_wait(input string tag);
        int n;
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
        check({tag, "_busy"}, busy, 1);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_init_cycles"}, n, 8);
    endtask

    task automatic stream(input int n, input logic [7:0] iv);
        in_valid = 1'b1; in_i = iv;
        repeat (n) tick();
        in_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input int n, input int start, input bit chk_val);
        int m;
        check({tag, "_count"}, o_v.size(), n);
        m = (o_v.size() < n) ? o_v.size() : n;
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_idx%0d", tag, i), o_idx[i], (start + i) % 8);
            check($sformatf("%s_lat%0d", tag, i), o_lat[i], 2);
            if (chk_val) begin
                check($sformatf("%s_v%0d", tag, i), o_v[i], exp_v[i]);
                check($sformatf("%s_spk%0d", tag, i), o_spk[i], exp_s[i]);
            end
        end
    endtask

    initial begin
        int rv[6];
        int rs[6];
        int nacc;
        rv = '{32'h03C0, 32'h354E, 32'hC400, 32'hC400, 32'hC400, 32'h03C0};
        rs = '{0, 0, 1, 0, 0, 0};

        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_v", out_v, 0);
        check("rst_out_spike", out_spike, 0);
        rst = 1'b0;

        cfg_write(2'd0, 16'hC400);
        cfg_write(2'd1, 16'h00C7);
        cfg_write(2'd2, 16'h3C00);
        cfg_write(2'd3, 16'h0002);
        go_and_wait("go1");

        clear_q();
        stream(8, 8'd0);
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            exp_v.push_back(32'hC400);
            exp_s.push_back(0);
        end
        check_outputs("zero_in", 8, 0, 1'b1);

        // Lowering the threshold while running must be ignored.
        cfg_write(2'd2, 16'h0000);
        clear_q();
        stream(48, 8'd255);
        repeat (4) tick();
        for (int i = 0; i < 48; i++) begin
            exp_v.push_back(rv[i / 8]);
            exp_s.push_back(rs[i / 8]);
        end
        check_outputs("full_in", 48, 0, 1'b1);

        clear_q();
        nacc = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_i = 8'($urandom_range(0, 255));
            if (in_valid) nacc++;
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check_outputs("hs", nacc, 0, 1'b0);

        clear_q();
        stream(2, 8'd255);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        check("stop_in_ready", in_ready, 0);
        check("stop_busy", busy, 0);
        repeat (5) tick();
        check("stop_no_out", o_v.size(), 0);

        cfg_write(2'd2, 16'h0300);
        go_and_wait("go2");
        clear_q();
        stream(2, 8'd255);
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            exp_v.push_back(32'hC400);
            exp_s.push_back(1);
        end
        check_outputs("reinit", 2, 0, 1'b1);

        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        cfg_write(2'd0, 16'h7000);
        cfg_write(2'd1, 16'h0000);
        cfg_write(2'd2, 16'h7FFF);
        cfg_write(2'd3, 16'h0000);
        go_and_wait("go3");
        clear_q();
        stream(16, 8'd255);
        repeat (4) tick();
        for (int i = 0; i < 16; i++) begin
            exp_v.push_back(32'h7000);
            exp_s.push_back(1);
        end
        check_outputs("sat", 16, 0, 1'b1);

        in_valid = 1'b1;
        in_i = 8'd255;
        repeat (5) tick();
        check("pre_rst_out_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_idx", out_idx, 0);
        check("mid_rst_out_v", out_v, 0);
        check("mid_rst_out_spike", out_spike, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
